// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx core among N_REQ byte producers.
// Optional watchdog abort of a stuck transfer is built when UART_ARB_WDOG_EN is defined.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_done,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   grant_id_r;
    logic [N_REQ-1:0]   req_ready_r;
    logic               tx_start_r;
    logic [7:0]         tx_data_r;
    logic               busy_r;

    logic               found_s;
    logic [IDX_W-1:0]   winner_s;
    logic [IDX_W-1:0]   cand_idx_s;
    int                 cand_v;
    logic [7:0]         win_byte_s;
    logic [IDX_W-1:0]   next_ptr_s;

`ifdef UART_ARB_WDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]   wdog_cnt_r;
    logic               timeout_err_r;
`endif

    // Round-robin search: first pending requester at or above rr_ptr, wrapping.
    always_comb begin
        found_s    = 1'b0;
        winner_s   = {IDX_W{1'b0}};
        cand_v     = 32'sd0;
        cand_idx_s = {IDX_W{1'b0}};
        for (int off = 32'sd0; off < N_REQ; off++) begin
            cand_v = int'(rr_ptr_r) + off;
            if (cand_v >= N_REQ) begin
                cand_v = cand_v - N_REQ;
            end else begin
                cand_v = cand_v;
            end
            cand_idx_s = IDX_W'(cand_v);
            if (!found_s && req_valid[cand_idx_s]) begin
                found_s  = 1'b1;
                winner_s = cand_idx_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Byte of the selected requester.
    always_comb begin
        win_byte_s = req_data[{winner_s, 3'b000} +: 8];
    end

    // Pointer advance past the last grant; explicit compare keeps non-power-of-2 N_REQ in range.
    always_comb begin
        if (grant_id_r == IDX_W'(N_REQ - 1)) begin
            next_ptr_s = {IDX_W{1'b0}};
        end else begin
            next_ptr_s = grant_id_r + IDX_W'(1'b1);
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= {IDX_W{1'b0}};
            grant_id_r    <= {IDX_W{1'b0}};
            req_ready_r   <= {N_REQ{1'b0}};
            tx_start_r    <= 1'b0;
            tx_data_r     <= 8'h00;
            busy_r        <= 1'b0;
`ifdef UART_ARB_WDOG_EN
            wdog_cnt_r    <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
`endif
        end else begin
            req_ready_r   <= {N_REQ{1'b0}};
            tx_start_r    <= 1'b0;
`ifdef UART_ARB_WDOG_EN
            timeout_err_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        state_r     <= ST_WAIT;
                        tx_data_r   <= win_byte_s;
                        grant_id_r  <= winner_s;
                        tx_start_r  <= 1'b1;
                        req_ready_r <= {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
                        busy_r      <= 1'b1;
`ifdef UART_ARB_WDOG_EN
                        wdog_cnt_r  <= {CNT_W{1'b0}};
`endif
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // tx_done is tested first so it wins over a simultaneous watchdog expiry.
                    if (tx_done) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= next_ptr_s;
                        busy_r   <= 1'b0;
                    end
`ifdef UART_ARB_WDOG_EN
                    else if (wdog_cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_r       <= ST_IDLE;
                        rr_ptr_r      <= next_ptr_s;
                        busy_r        <= 1'b0;
                        timeout_err_r <= 1'b1;
                    end else begin
                        wdog_cnt_r    <= wdog_cnt_r + CNT_W'(1'b1);
                    end
`else
                    else begin
                        state_r <= ST_WAIT;
                    end
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign grant_id  = grant_id_r;
    assign busy      = busy_r;

`ifdef UART_ARB_WDOG_EN
    assign timeout_err = timeout_err_r;
`else
    // No watchdog in this build; TIMEOUT_CYC is referenced only to keep the parameter list uniform.
    assign timeout_err = 1'b0 & (TIMEOUT_CYC == 0);
`endif

endmodule
